// File: rtl/fxp_pkg.sv
// Fixed-point helpers shared by requantizing / clipping stages.
package fxp_pkg;

  function automatic longint out_max(input int width);
    return (longint'(1) <<< (width - 1)) - 1;
  endfunction

  function automatic longint out_min(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

  // Positive: fractional bits removed; zero or negative: bits appended.
  function automatic int drop_bits(input int in_point, input int out_point);
    return in_point - out_point;
  endfunction

  function automatic logic half_even_up(input logic guard, input logic sticky, input logic lsb);
    return guard & (sticky | lsb);
  endfunction

endpackage

// File: rtl/signed_requant_round_if.sv
// Sample stream in, requantized stream plus frame saturation report out.
interface signed_requant_round_if #(
  parameter int DIN_WIDTH  = 16,
  parameter int DOUT_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic signed [DIN_WIDTH-1:0] din;
  logic                        din_valid;
  logic                        din_last;
  logic [DOUT_WIDTH-1:0]       dout;
  logic                        dout_valid;
  logic                        dout_last;
  logic                        dout_sat;
  logic [CNT_WIDTH-1:0]        sat_count;
  logic                        sat_count_valid;

  modport master (
    output din, din_valid, din_last,
    input  dout, dout_valid, dout_last, dout_sat, sat_count, sat_count_valid
  );

  modport slave (
    input  din, din_valid, din_last,
    output dout, dout_valid, dout_last, dout_sat, sat_count, sat_count_valid
  );
endinterface

// File: rtl/sat_event_counter.sv
// Sticky saturation-event counter with frame-end snapshot and clear.
module sat_event_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 frame_end,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 count_valid
);
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;

  // Saturates at all-ones; the snapshot includes the frame-end sample itself.
  always_comb begin
    cnt_nxt = (cnt == '1) ? cnt : cnt + CNT_WIDTH'(inc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      count       <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= frame_end;
      if (frame_end) begin
        count <= cnt_nxt;
        cnt   <= '0;
      end else begin
        cnt <= cnt_nxt;
      end
    end
  end
endmodule

// File: rtl/signed_requant_round.sv
// Three-stage signed requantizer: split, round-half-even, saturate; with
// per-sample clip flag and per-frame clip count.
module signed_requant_round
  import fxp_pkg::*;
#(
  parameter int DIN_WIDTH  = 16,
  parameter int DIN_POINT  = 8,
  parameter int DOUT_WIDTH = 8,
  parameter int DOUT_POINT = 4,
  parameter int CNT_WIDTH  = 16
) (
  input logic clk,
  input logic rst,
  signed_requant_round_if.slave bus
);
  localparam int STAGES = 3;
  localparam int DROP   = drop_bits(DIN_POINT, DOUT_POINT);
  localparam int TW     = (DROP > 0) ? DIN_WIDTH : DIN_WIDTH - DROP;
  localparam int SW     = TW + 1;
  localparam int CW     = ((SW > DOUT_WIDTH) ? SW : DOUT_WIDTH) + 1;
  localparam logic signed [CW-1:0] MAX_V = CW'(out_max(DOUT_WIDTH));
  localparam logic signed [CW-1:0] MIN_V = CW'(out_min(DOUT_WIDTH));

  if (DOUT_WIDTH - DOUT_POINT < 1 || DIN_WIDTH < 2) begin : g_bad_cfg
    $error("signed_requant_round: need DOUT_WIDTH-DOUT_POINT >= 1 and DIN_WIDTH >= 2");
  end

  logic [STAGES:1]       vld_pipe;
  logic [STAGES:1]       last_pipe;
  logic signed [TW-1:0]  trunc_c;
  logic                  guard_c;
  logic                  sticky_c;
  logic signed [TW-1:0]  s1_trunc;
  logic                  s1_guard;
  logic                  s1_sticky;
  logic                  round_up;
  logic signed [SW-1:0]  s2_sum;
  logic signed [CW-1:0]  sum_ext;
  logic                  sat_hi;
  logic                  sat_lo;

  if (DROP > 0) begin : g_narrow
    assign trunc_c = bus.din >>> DROP;
    assign guard_c = bus.din[DROP-1];
    if (DROP > 1) begin : g_sticky
      assign sticky_c = |bus.din[DROP-2:0];
    end else begin : g_no_sticky
      assign sticky_c = 1'b0;
    end
  end else begin : g_widen
    assign trunc_c  = TW'(bus.din) << (-DROP);
    assign guard_c  = 1'b0;
    assign sticky_c = 1'b0;
  end

  assign round_up = half_even_up(s1_guard, s1_sticky, s1_trunc[0]);
  // One bit of headroom means the rounding carry can never wrap.
  assign sum_ext  = CW'(s2_sum);
  assign sat_hi   = sum_ext > MAX_V;
  assign sat_lo   = sum_ext < MIN_V;

  always_ff @(posedge clk) begin
    s1_trunc  <= trunc_c;
    s1_guard  <= guard_c;
    s1_sticky <= sticky_c;
    s2_sum    <= SW'(s1_trunc) + {{(SW-1){1'b0}}, round_up};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe     <= '0;
      last_pipe    <= '0;
      bus.dout     <= '0;
      bus.dout_sat <= 1'b0;
    end else begin
      vld_pipe     <= {vld_pipe[STAGES-1:1], bus.din_valid};
      last_pipe    <= {last_pipe[STAGES-1:1], bus.din_valid & bus.din_last};
      bus.dout_sat <= vld_pipe[2] & (sat_hi | sat_lo);
      if (vld_pipe[2])
        bus.dout <= sat_hi ? MAX_V[DOUT_WIDTH-1:0] :
                    sat_lo ? MIN_V[DOUT_WIDTH-1:0] : sum_ext[DOUT_WIDTH-1:0];
    end
  end

  assign bus.dout_valid = vld_pipe[STAGES];
  assign bus.dout_last  = last_pipe[STAGES];

  sat_event_counter #(.CNT_WIDTH(CNT_WIDTH)) u_sat_cnt (
    .clk        (clk),
    .rst        (rst),
    .inc        (vld_pipe[2] & (sat_hi | sat_lo)),
    .frame_end  (vld_pipe[2] & last_pipe[2]),
    .count      (bus.sat_count),
    .count_valid(bus.sat_count_valid)
  );
endmodule

// File: tb/tb_signed_requant_round.sv
// Random + directed stimulus on three configurations against an arithmetic model.
module tb_signed_requant_round;
  typedef struct { int din_w; int din_pt; int dout_w; int dout_pt; int cnt_w; } cfg_t;
  typedef struct { bit v; bit l; bit sat; longint q; } item_t;
  typedef struct {
    item_t p0; item_t p1; int n;
    bit vout; bit lout; bit sout; bit svld;
    longint dout; longint cnt; longint satc;
  } mst_t;

  localparam cfg_t CA = '{16, 8, 8, 4, 16};
  localparam cfg_t CB = '{16, 8, 8, 4, 4};
  localparam cfg_t CC = '{8, 4, 16, 11, 16};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic        lst = 1'b0;
  logic [15:0] da  = '0;
  logic [7:0]  dc  = '0;
  int errors = 0;
  int checks = 0;
  mst_t sa, sb, sc;

  signed_requant_round_if #(.DIN_WIDTH(16), .DOUT_WIDTH(8),  .CNT_WIDTH(16)) ia();
  signed_requant_round_if #(.DIN_WIDTH(16), .DOUT_WIDTH(8),  .CNT_WIDTH(4))  ib();
  signed_requant_round_if #(.DIN_WIDTH(8),  .DOUT_WIDTH(16), .CNT_WIDTH(16)) ic();

  assign ia.din = da; assign ia.din_valid = vld; assign ia.din_last = lst;
  assign ib.din = da; assign ib.din_valid = vld; assign ib.din_last = lst;
  assign ic.din = dc; assign ic.din_valid = vld; assign ic.din_last = lst;

  signed_requant_round #(.DIN_WIDTH(16), .DIN_POINT(8), .DOUT_WIDTH(8), .DOUT_POINT(4), .CNT_WIDTH(16))
    dut_a (.clk(clk), .rst(rst), .bus(ia));
  signed_requant_round #(.DIN_WIDTH(16), .DIN_POINT(8), .DOUT_WIDTH(8), .DOUT_POINT(4), .CNT_WIDTH(4))
    dut_b (.clk(clk), .rst(rst), .bus(ib));
  signed_requant_round #(.DIN_WIDTH(8), .DIN_POINT(4), .DOUT_WIDTH(16), .DOUT_POINT(11), .CNT_WIDTH(16))
    dut_c (.clk(clk), .rst(rst), .bus(ic));

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Exact value scaled to the output grid, ties to even, then clamped.
  function automatic item_t mk(input cfg_t c, input bit v, input bit l, input longint raw);
    item_t it;
    longint d, q, den, rem, mx, mn;
    int drop;
    d = raw & ((longint'(1) << c.din_w) - 1);
    if (d >= (longint'(1) << (c.din_w - 1))) d -= (longint'(1) << c.din_w);
    drop = c.din_pt - c.dout_pt;
    if (drop > 0) begin
      den = longint'(1) << drop;
      q = d / den;
      if (d % den != 0 && d < 0) q -= 1;
      rem = d - q * den;
      if (2 * rem > den || (2 * rem == den && q % 2 != 0)) q += 1;
    end else begin
      q = d * (longint'(1) << (-drop));
    end
    mx = (longint'(1) << (c.dout_w - 1)) - 1;
    mn = -mx - 1;
    it.sat = (q > mx) || (q < mn);
    if (q > mx) q = mx;
    if (q < mn) q = mn;
    it.q = q & ((longint'(1) << c.dout_w) - 1);
    it.v = v;
    it.l = v & l;
    return it;
  endfunction

  // Samples emerge two edges after capture; reset discards anything not yet out.
  task automatic step(input cfg_t c, input bit r, input bit v, input bit l, input longint raw,
                      inout mst_t s);
    item_t o, nw;
    longint cap;
    cap = (longint'(1) << c.cnt_w) - 1;
    if (r) begin
      s.n = 0; s.vout = 0; s.lout = 0; s.sout = 0; s.svld = 0;
      s.dout = 0; s.cnt = 0; s.satc = 0;
      return;
    end
    nw = mk(c, v, l, raw);
    o = '{v: 1'b0, l: 1'b0, sat: 1'b0, q: 0};
    if (s.n == 2) o = s.p0;
    else s.n++;
    s.p0 = s.p1;
    s.p1 = nw;
    s.vout = o.v; s.lout = o.l; s.sout = o.v & o.sat; s.svld = o.v & o.l;
    if (o.v) begin
      s.dout = o.q;
      if (o.l) begin
        s.satc = (s.cnt + longint'(o.sat) > cap) ? cap : s.cnt + longint'(o.sat);
        s.cnt = 0;
      end else if (o.sat && s.cnt < cap) begin
        s.cnt++;
      end
    end
  endtask

  task automatic chk_dut(input string p, input mst_t s, input logic v, input logic l,
                         input logic sat, input longint d, input longint scnt, input logic sv);
    chk({p, ".dout_valid"}, longint'(v), longint'(s.vout));
    chk({p, ".dout_last"}, longint'(l), longint'(s.lout));
    chk({p, ".dout_sat"}, longint'(sat), longint'(s.sout));
    chk({p, ".dout"}, d, s.dout);
    chk({p, ".sat_count_valid"}, longint'(sv), longint'(s.svld));
    chk({p, ".sat_count"}, scnt, s.satc);
  endtask

  task automatic cyc(input bit r, input bit v, input bit l, input logic [15:0] a, input logic [7:0] cc);
    @(negedge clk);
    rst = r; vld = v; lst = l; da = a; dc = cc;
    @(posedge clk);
    step(CA, r, v, l, longint'(a), sa);
    step(CB, r, v, l, longint'(a), sb);
    step(CC, r, v, l, longint'(cc), sc);
    #1;
    chk_dut("A", sa, ia.dout_valid, ia.dout_last, ia.dout_sat, longint'(ia.dout),
            longint'(ia.sat_count), ia.sat_count_valid);
    chk_dut("B", sb, ib.dout_valid, ib.dout_last, ib.dout_sat, longint'(ib.dout),
            longint'(ib.sat_count), ib.sat_count_valid);
    chk_dut("C", sc, ic.dout_valid, ic.dout_last, ic.dout_sat, longint'(ic.dout),
            longint'(ic.sat_count), ic.sat_count_valid);
  endtask

  function automatic logic [15:0] rnd_ns();
    return 16'($urandom_range(0, 4032) - 2016);
  endfunction

  function automatic logic [15:0] sat_pick();
    case ($urandom_range(0, 4))
      0:       return 16'h7F00;
      1:       return 16'h8000;
      2:       return 16'h07F8;
      3:       return 16'h0900;
      default: return 16'hF000;
    endcase
  endfunction

  logic [15:0] dir_a [8];
  logic [15:0] t;

  initial begin
    dir_a = '{16'h0118, 16'h0128, 16'h0129, 16'hFEE8, 16'h7F00, 16'h8000, 16'h07F8, 16'hF800};
    repeat (3) cyc(1, 0, 0, 16'h0, 8'h0);

    for (int i = 0; i < 8; i++)
      cyc(0, 1, i == 7, dir_a[i], (i == 0) ? 8'h9C : (i == 1) ? 8'h7F : 8'($urandom));
    repeat (3) cyc(0, 0, 0, rnd_ns(), 8'($urandom));

    // Ten-sample frame, three clips including the last, with gaps.
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 1) cyc(0, 0, 1, rnd_ns(), 8'($urandom));
      cyc(0, 1, i == 9, (i == 2 || i == 5 || i == 9) ? sat_pick() : rnd_ns(), 8'($urandom));
    end
    for (int i = 0; i < 5; i++) cyc(0, 1, i == 4, rnd_ns(), 8'($urandom));

    for (int i = 0; i < 20; i++) cyc(0, 1, 0, sat_pick(), 8'($urandom));
    cyc(0, 1, 1, rnd_ns(), 8'($urandom));

    // Reset with two clipped samples counted and two more in flight.
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, sat_pick(), 8'($urandom));
    cyc(1, 0, 0, 16'h0, 8'h0);
    for (int i = 0; i < 4; i++) cyc(0, 1, i == 3, (i == 1) ? sat_pick() : rnd_ns(), 8'($urandom));
    repeat (3) cyc(0, 0, 0, rnd_ns(), 8'($urandom));
    cyc(0, 1, 1, sat_pick(), 8'($urandom));
    repeat (3) cyc(0, 0, 0, rnd_ns(), 8'($urandom));

    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 3))
        0:       t = sat_pick();
        1:       t = 16'($urandom);
        2:       begin t = rnd_ns(); t[3:0] = 4'h8; end
        default: t = rnd_ns();
      endcase
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
          t, 8'($urandom));
    end
    repeat (4) cyc(0, 0, 0, 16'h0, 8'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
